instr_encoder_rv32i: RTL and testbench
======================================

# instr_encoder_rv32i

Streaming RV32I instruction encoder: accepts one instruction per handshake as a mnemonic code plus register and immediate fields, and packs it into a 32-bit RV32I word. It writes the words sequentially into instruction memory through a simple write port. It is the inverse of the core's control/decode path and serves as the on-chip program loader used before the core is released from reset.

## Interface
- `DEPTH`, 256: number of instruction-memory words; requires 1 ≤ DEPTH ≤ 2**ADDR_W.
- `ADDR_W`, 8: width of the word address.
- `clock` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that (re)starts a load at word address 0.
- `in_valid` input 1: instruction fields are valid.
- `in_ready` output 1: encoder accepts this cycle.
- `in_mnem` input 6: mnemonic code (see Operation).
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_imm` input 32: immediate, or byte offset for branches and jumps.
- `wr_en` output 1: instruction-memory write strobe.
- `wr_addr` output ADDR_W: word address.
- `wr_data` output 32: encoded instruction.
- `count` output ADDR_W+1: number of words written since the last `start`.
- `full` output 1: `count` == DEPTH.
- `err_illegal` output 1: sticky flag; an illegal mnemonic was seen.
- `err_range` output 1: sticky flag; an immediate was out of range.

## Operation
- Mnemonic codes:
  - 0–9: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - 10–18: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - 19–23: LB LH LW LBU LHU.
  - 24–26: SB SH SW.
  - 27–32: BEQ BNE BLT BGE BLTU BGEU.
  - 33–36: LUI AUIPC JAL JALR.
  - Codes 37–63 are illegal.
- Standard RV32I opcodes, funct3 and funct7 apply. SUB and SRA/SRAI use funct7 0x20; all others use 0x00.
- Fields not used by the format are encoded as 0.
- Immediate packing:
  - I-type: `in_imm[11:0]`.
  - Shift-immediates: `in_imm[4:0]` as shamt.
  - S-type: `in_imm[11:0]` split into [31:25] and [11:7].
  - B-type: `in_imm[12:1]` in standard order.
  - U-type: `in_imm[19:0]` into [31:12].
  - J-type: `in_imm[20:1]` in standard order.
- States:
  - IDLE: after reset; `in_ready`=0.
  - LOAD: `in_ready`=1.
  - FULL: `in_ready`=0.
- Transitions:
  - `start` in any state → LOAD. The same edge clears the pointer, `count` and both error flags.
  - LOAD → FULL when the DEPTH-th legal word is accepted.
- Accept = `in_valid` & `in_ready`. During the `start` cycle `in_ready` is forced to 0, so `start` wins over a simultaneous accept.
- On a legal accept:
  - The word is assigned `wr_addr` = pointer.
  - The pointer increments at the same edge.
  - `count` = pointer.
- On an illegal or out-of-range accept:
  - The input is consumed and no write occurs.
  - The pointer is unchanged.
  - The matching sticky flag is set.
- When both errors apply to one accept, only `err_illegal` is set.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `in_ready`=0, `count`=0, `full`=0, both error flags 0, state IDLE.
- Latency: an accept at edge N produces `wr_en`=1 with `wr_addr`/`wr_data` valid during the cycle after N, for exactly one cycle.
- Throughput: one word per cycle.
- `wr_en` is 0 in every cycle not following a legal accept.
- `full` and the FULL state take effect the cycle after the last legal accept. The final write still issues in that cycle.
- `in_ready` is a registered function of state and must not depend combinationally on `in_valid`.
- `start` during a pending write: that write still issues with its original address. The pointer restarts at 0.
- Reset mid-operation: all outputs return to reset values immediately, and any pending write is dropped.

## Configuration
- Macro: `ENC_RANGE_CHECK_EN`.
- With the macro defined, an accept is out of range (`err_range`, no write) when:
  - I-type or S-type: `in_imm` is not a signed 12-bit value.
  - Shift-immediate: `in_imm[31:5]` ≠ 0.
  - B-type: `in_imm` is not signed 13-bit, or `in_imm[0]`=1.
  - J-type: `in_imm` is not signed 21-bit, or `in_imm[0]`=1.
  - U-type: `in_imm[31:20]` ≠ 0.
- Without the macro:
  - Immediates are silently truncated per the packing rules.
  - `err_range` is tied to 0.

## Test plan
- Basic encodes after `start`:
  - ADDI x1,x0,5 → 0x00500093 @0
  - SUB x3,x1,x2 → 0x402081B3 @1
  - SW x2,8(x1) → 0x0020A423 @2
  - One cycle of latency each; `count`=3.
- Branch, jump and upper-immediate encodes:
  - BEQ x1,x2,-4 → 0xFE208EE3
  - JAL x1,2048 → 0x001000EF
  - LUI x5,0x12345 → 0x123452B7
- Illegal mnemonic: `in_mnem`=40 → no `wr_en`, `err_illegal`=1, `count` unchanged. The next legal word takes the unused address.
- Range error, macro defined: ADDI imm=2048 → no write and `err_range`=1. Without the macro → 0x80000013 written.
- Full condition with DEPTH=4: stream 5 words back-to-back → writes @0–3, `full`=1, `in_ready`=0, 5th held. Then `start` → `count`=0, `full`=0, 5th written @0.
- Reset and `start` priority: `start` coincident with `in_valid` → not accepted. `reset_n` low during a pending write → `wr_en` drops immediately; all outputs return to reset values.

Source files
------------

// File: rtl/instr_encoder_rv32i_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_encoder_rv32i_if                                          |
// | Brief    : Instruction-field handshake and memory write port of the encoder |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface instr_encoder_rv32i_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_mnem;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_rv32i.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_encoder_rv32i                                             |
// | Brief    : Streaming RV32I encoder / program loader into instruction memory.|
// |            Optional immediate range checking: ENC_RANGE_CHECK_EN           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_encoder_rv32i #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  instr_encoder_rv32i_if.slave  bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err_illegal,
  output logic                  err_range
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_LAST  = (ADDR_W+1)'(DEPTH - 1);

  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  localparam logic [2:0] c_FMT_R  = 3'd0;
  localparam logic [2:0] c_FMT_I  = 3'd1;
  localparam logic [2:0] c_FMT_SH = 3'd2;
  localparam logic [2:0] c_FMT_S  = 3'd3;
  localparam logic [2:0] c_FMT_B  = 3'd4;
  localparam logic [2:0] c_FMT_U  = 3'd5;
  localparam logic [2:0] c_FMT_J  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_err_illegal;
  logic              r_err_range;

  logic [2:0]  w_fmt;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_illegal;
  logic        w_range;
  logic [31:0] w_word;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_write;

  // Mnemonic to format, opcode, funct3 and funct7.
  always_comb begin
    w_fmt     = c_FMT_R;
    w_op      = c_OP_REG;
    w_f3      = 3'd0;
    w_f7      = 7'd0;
    w_illegal = 1'b0;
    case (bus.in_mnem)
      6'd0:  w_f3 = 3'd0;
      6'd1:  begin w_f3 = 3'd0; w_f7 = 7'h20; end
      6'd2:  w_f3 = 3'd1;
      6'd3:  w_f3 = 3'd2;
      6'd4:  w_f3 = 3'd3;
      6'd5:  w_f3 = 3'd4;
      6'd6:  w_f3 = 3'd5;
      6'd7:  begin w_f3 = 3'd5; w_f7 = 7'h20; end
      6'd8:  w_f3 = 3'd6;
      6'd9:  w_f3 = 3'd7;
      6'd10: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd0; end
      6'd11: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd2; end
      6'd12: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd3; end
      6'd13: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd4; end
      6'd14: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd6; end
      6'd15: begin w_fmt = c_FMT_I;  w_op = c_OP_IMM; w_f3 = 3'd7; end
      6'd16: begin w_fmt = c_FMT_SH; w_op = c_OP_IMM; w_f3 = 3'd1; end
      6'd17: begin w_fmt = c_FMT_SH; w_op = c_OP_IMM; w_f3 = 3'd5; end
      6'd18: begin w_fmt = c_FMT_SH; w_op = c_OP_IMM; w_f3 = 3'd5; w_f7 = 7'h20; end
      6'd19: begin w_fmt = c_FMT_I;  w_op = c_OP_LOAD; w_f3 = 3'd0; end
      6'd20: begin w_fmt = c_FMT_I;  w_op = c_OP_LOAD; w_f3 = 3'd1; end
      6'd21: begin w_fmt = c_FMT_I;  w_op = c_OP_LOAD; w_f3 = 3'd2; end
      6'd22: begin w_fmt = c_FMT_I;  w_op = c_OP_LOAD; w_f3 = 3'd4; end
      6'd23: begin w_fmt = c_FMT_I;  w_op = c_OP_LOAD; w_f3 = 3'd5; end
      6'd24: begin w_fmt = c_FMT_S;  w_op = c_OP_STORE; w_f3 = 3'd0; end
      6'd25: begin w_fmt = c_FMT_S;  w_op = c_OP_STORE; w_f3 = 3'd1; end
      6'd26: begin w_fmt = c_FMT_S;  w_op = c_OP_STORE; w_f3 = 3'd2; end
      6'd27: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd0; end
      6'd28: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd1; end
      6'd29: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd4; end
      6'd30: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd5; end
      6'd31: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd6; end
      6'd32: begin w_fmt = c_FMT_B;  w_op = c_OP_BRANCH; w_f3 = 3'd7; end
      6'd33: begin w_fmt = c_FMT_U;  w_op = c_OP_LUI; end
      6'd34: begin w_fmt = c_FMT_U;  w_op = c_OP_AUIPC; end
      6'd35: begin w_fmt = c_FMT_J;  w_op = c_OP_JAL; end
      6'd36: begin w_fmt = c_FMT_I;  w_op = c_OP_JALR; w_f3 = 3'd0; end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_word = 32'd0;
    case (w_fmt)
      c_FMT_R:  w_word = {w_f7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, w_op};
      c_FMT_I:  w_word = {bus.in_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
      c_FMT_SH: w_word = {w_f7, bus.in_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
      c_FMT_S:  w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, bus.in_imm[4:0], w_op};
      c_FMT_B:  w_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                          bus.in_imm[4:1], bus.in_imm[11], w_op};
      c_FMT_U:  w_word = {bus.in_imm[19:0], bus.in_rd, w_op};
      c_FMT_J:  w_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                          bus.in_rd, w_op};
      default:  w_word = 32'd0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A value fits signed N bits when bits [31:N-1] are all equal.
  always_comb begin
    w_range = 1'b0;
    case (w_fmt)
      c_FMT_I, c_FMT_S: w_range = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      c_FMT_SH:         w_range = |bus.in_imm[31:5];
      c_FMT_B:          w_range = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
      c_FMT_J:          w_range = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) || bus.in_imm[0];
      c_FMT_U:          w_range = |bus.in_imm[31:20];
      default:          w_range = 1'b0;
    endcase
  end
`else
  logic w_unused_imm_hi;
  assign w_unused_imm_hi = ^bus.in_imm[31:21];
  assign w_range         = 1'b0;
`endif

  // start masks in_ready so it always wins over a coincident handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state == S_LOAD) && !start;
    w_accept    = bus.in_valid && w_in_ready;
    w_write     = w_accept && !w_illegal && !w_range;
    if (start) begin
      w_state_nxt = S_LOAD;
    end else if ((r_state == S_LOAD) && w_write && (r_ptr == c_LAST)) begin
      w_state_nxt = S_FULL;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 32'd0;
      r_err_illegal <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= r_ptr[ADDR_W-1:0];
        r_wr_data <= w_word;
      end
      if (start) begin
        r_ptr         <= '0;
        r_err_illegal <= 1'b0;
        r_err_range   <= 1'b0;
      end else if (w_accept) begin
        if (w_illegal) begin
          r_err_illegal <= 1'b1;
        end else if (w_range) begin
          r_err_range <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign count        = r_ptr;
  assign full         = (r_ptr == c_DEPTH);
  assign err_illegal  = r_err_illegal;
  assign err_range    = r_err_range;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_rv32i.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_encoder_rv32i                                          |
// | Brief    : Directed plus random bench for instr_encoder_rv32i              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_encoder_rv32i;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  // funct3 per mnemonic code 0..36
  localparam int F3_TAB [0:36] = '{0,0,1,2,3,4,5,5,6,7, 0,2,3,4,6,7,1,5,5,
                                   0,1,2,4,5, 0,1,2, 0,1,4,5,6,7, 0,0,0,0};

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic [ADDR_W:0] count;
  logic            full;
  logic            err_illegal;
  logic            err_range;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_active = 1'b0;
  int          m_count  = 0;
  bit          m_eil    = 1'b0;
  bit          m_erg    = 1'b0;
  bit          m_wen    = 1'b0;
  int          m_addr   = 0;
  logic [31:0] m_data   = 32'd0;

  instr_encoder_rv32i_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_rv32i #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .bus         (bus),
    .count       (count),
    .full        (full),
    .err_illegal (err_illegal),
    .err_range   (err_range)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_encode(int m, logic [31:0] rd, logic [31:0] rs1,
                                             logic [31:0] rs2, logic [31:0] imm);
    logic [31:0] f3, f7, regs_r, regs_i;
    f3 = F3_TAB[m];
    f7 = (m == 1 || m == 7 || m == 18) ? 32'h20 : 32'h0;
    regs_r = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
    regs_i = (rs1 << 15) | (f3 << 12) | (rd << 7);
    if (m <= 9)  return (f7 << 25) | regs_r | (rd << 7) | 32'h33;
    if (m <= 15) return ((imm & 32'hFFF) << 20) | regs_i | 32'h13;
    if (m <= 18) return (f7 << 25) | ((imm & 32'h1F) << 20) | regs_i | 32'h13;
    if (m <= 23) return ((imm & 32'hFFF) << 20) | regs_i | 32'h03;
    if (m <= 26) return (((imm >> 5) & 32'h7F) << 25) | regs_r | ((imm & 32'h1F) << 7) | 32'h23;
    if (m <= 32) return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs_r |
                        (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
    if (m == 33) return ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h37;
    if (m == 34) return ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h17;
    if (m == 35) return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                        (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
    return ((imm & 32'hFFF) << 20) | regs_i | 32'h67;
  endfunction

  function automatic bit ref_range(int m, logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (!RANGE_EN) return 1'b0;
    if ((m >= 10 && m <= 15) || (m >= 19 && m <= 26) || m == 36) return (s < -2048 || s > 2047);
    if (m >= 16 && m <= 18) return (imm > 32'd31);
    if (m >= 27 && m <= 32) return (s < -4096 || s > 4095 || imm[0]);
    if (m == 35) return (s < -1048576 || s > 1048575 || imm[0]);
    if (m == 33 || m == 34) return (imm >= 32'h100000);
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_en", 64'(bus.wr_en), 64'(m_wen));
    if (m_wen) begin
      chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
      chk("wr_data", 64'(bus.wr_data), 64'(m_data));
    end
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_count == DEPTH));
    chk("in_ready", 64'(bus.in_ready), 64'(m_active && m_count < DEPTH && !start));
    chk("err_illegal", 64'(err_illegal), 64'(m_eil));
    chk("err_range", 64'(err_range), 64'(m_erg));
  endtask

  // One clock: predict the edge from current inputs, then compare just after it.
  task automatic step();
    bit acc, ill, rng;
    logic [31:0] word;
    int m;
    m    = int'(bus.in_mnem);
    acc  = bus.in_valid && m_active && (m_count < DEPTH) && !start;
    ill  = (m > 36);
    rng  = !ill && ref_range(m, bus.in_imm);
    word = ill ? 32'd0 : ref_encode(m, 32'(bus.in_rd), 32'(bus.in_rs1), 32'(bus.in_rs2), bus.in_imm);
    @(posedge clock);
    m_wen = acc && !ill && !rng;
    if (m_wen) begin
      m_addr = m_count;
      m_data = word;
    end
    if (start) begin
      m_count = 0; m_eil = 1'b0; m_erg = 1'b0; m_active = 1'b1;
    end else if (acc) begin
      if (ill) m_eil = 1'b1;
      else if (rng) m_erg = 1'b1;
      else m_count++;
    end
    #1;
    check_all();
  endtask

  task automatic drive(int m, int rd, int rs1, int rs2, logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_mnem  = 6'(m);
    bus.in_rd    = 5'(rd);
    bus.in_rs1   = 5'(rs1);
    bus.in_rs2   = 5'(rs2);
    bus.in_imm   = imm;
  endtask

  task automatic send(int m, int rd, int rs1, int rs2, logic [31:0] imm);
    drive(m, rd, rs1, rs2, imm);
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_word(string tag, int addr, logic [31:0] word);
    chk({tag, "_wen"}, 64'(bus.wr_en), 64'd1);
    chk({tag, "_addr"}, 64'(bus.wr_addr), 64'(addr));
    chk({tag, "_data"}, 64'(bus.wr_data), 64'(word));
  endtask

  task automatic expect_reset_values(string tag);
    chk({tag, "_wen"}, 64'(bus.wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_eil"}, 64'(err_illegal), 64'd0);
    chk({tag, "_erg"}, 64'(err_range), 64'd0);
  endtask

  initial begin
    drive(10, 1, 0, 0, 32'd5);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    expect_reset_values("reset");
    reset_n = 1'b1;

    // IDLE ignores valid input
    send(10, 1, 0, 0, 32'd5);
    chk("idle_no_write", 64'(bus.wr_en), 64'd0);

    // start coincident with valid is not accepted
    drive(10, 1, 0, 0, 32'd5);
    do_start();
    chk("start_prio_wen", 64'(bus.wr_en), 64'd0);
    chk("start_prio_count", 64'(count), 64'd0);

    send(10, 1, 0, 0, 32'd5);      expect_word("addi", 0, 32'h00500093);
    send(1, 3, 1, 2, 32'd0);       expect_word("sub", 1, 32'h402081B3);
    send(26, 0, 1, 2, 32'd8);      expect_word("sw", 2, 32'h0020A423);
    idle();
    chk("basic_count", 64'(count), 64'd3);

    do_start();
    send(27, 0, 1, 2, 32'hFFFF_FFFC); expect_word("beq", 0, 32'hFE208EE3);
    send(35, 1, 0, 0, 32'd2048);      expect_word("jal", 1, 32'h001000EF);
    send(33, 5, 0, 0, 32'h12345);     expect_word("lui", 2, 32'h123452B7);
    idle();

    // illegal mnemonic is consumed without a write
    do_start();
    send(40, 1, 2, 3, 32'd0);
    chk("illegal_wen", 64'(bus.wr_en), 64'd0);
    chk("illegal_flag", 64'(err_illegal), 64'd1);
    chk("illegal_count", 64'(count), 64'd0);
    send(10, 1, 0, 0, 32'd5);      expect_word("after_illegal", 0, 32'h00500093);

    send(10, 0, 0, 0, 32'd2048);
    if (RANGE_EN) begin
      chk("range_wen", 64'(bus.wr_en), 64'd0);
      chk("range_flag", 64'(err_range), 64'd1);
    end else begin
      expect_word("range_trunc", 1, 32'h80000013);
    end
    idle();

    // fill all DEPTH words back-to-back; the fifth is held
    do_start();
    send(10, 1, 0, 0, 32'd1);      expect_word("fill0", 0, 32'h00100093);
    send(10, 2, 0, 0, 32'd2);      expect_word("fill1", 1, 32'h00200113);
    send(10, 3, 0, 0, 32'd3);      expect_word("fill2", 2, 32'h00300193);
    send(10, 4, 0, 0, 32'd4);      expect_word("fill3", 3, 32'h00400213);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    send(10, 5, 0, 0, 32'd5);
    chk("held_wen", 64'(bus.wr_en), 64'd0);
    do_start();
    chk("restart_count", 64'(count), 64'd0);
    chk("restart_full", 64'(full), 64'd0);
    step();                        expect_word("held_written", 0, 32'h00500293);
    idle();

    // asynchronous reset during a pending write
    do_start();
    send(10, 6, 0, 0, 32'd7);
    chk("pending_wen", 64'(bus.wr_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    expect_reset_values("async_reset");
    m_active = 1'b0; m_count = 0; m_eil = 1'b0; m_erg = 1'b0; m_wen = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle();

    // randomized traffic against the model
    for (int round = 0; round < 25; round++) begin
      do_start();
      for (int k = 0; k < 12; k++) begin
        int m, sel;
        logic [31:0] imm;
        m   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36));
        sel = int'($urandom_range(0, 3));
        case (sel)
          0:       imm = $urandom;
          1:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
          2:       imm = 32'(int'($urandom_range(0, 4095)) - 2048) & 32'hFFFF_FFFE;
          default: imm = 32'($urandom_range(0, 40));
        endcase
        drive(m, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), imm);
        bus.in_valid = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        step();
        start = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
